// File: rtl/bcd_scan_controller.sv
// Binary-to-BCD converter (shift-add-3, one bit per cycle) with a 4-digit 7-segment scan driver.
// Latency: value accepted at edge k appears on bcd_out with a done pulse after edge k+N+1; one value per N+2 cycles.
// Backpressure: in_ready is high only in IDLE; the display scan is free-running and never stalls.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (the units digit always shows).
module bcd_scan_controller #(
  parameter int N        = 10,
  parameter int SCAN_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         done,
  output logic [15:0]  bcd_out,
  output logic [0:6]   seg_n,
  output logic [3:0]   an_n
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [15:0]     scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     adj;
  logic [3:0]      digit;
  logic            blank;

  // Add 3 to every nibble that is 5 or more, so the following left shift carries correctly in decimal.
  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low segment pattern, bit order a..g; anything above 9 is shown blank.
  function automatic logic [0:6] decode(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State registers for the converter and the scan driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      scan_q    <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
    end
  end

  // Converter FSM: capture, N shift-add-3 steps, then commit to the display buffer.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    adj       = add3(scratch_q);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d   = in_data;
          scratch_d = '0;
          cnt_d     = CW'(N);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = {adj[14:0], shift_q[N-1]};
        shift_d   = {shift_q[N-2:0], 1'b0};
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running scan: each digit stays lit SCAN_DIV cycles, then the index advances.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 1'b1;
    end
  end

  // Select the nibble for the lit digit and decide whether it is a leading zero to blank.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (idx_q)
      2'd0: digit = bcd_q[3:0];
      2'd1: digit = bcd_q[7:4];
      2'd2: digit = bcd_q[11:8];
      2'd3: digit = bcd_q[15:12];
      default: digit = 4'd0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd1: blank = (bcd_q[15:4] == 12'd0);
      2'd2: blank = (bcd_q[15:8] == 8'd0);
      2'd3: blank = (bcd_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  assign in_ready = (state_q == S_IDLE);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign an_n     = ~(4'b0001 << idx_q);
  assign seg_n    = blank ? 7'b1111111 : decode(digit);

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Directed bench for bcd_scan_controller: conversion latency, handshake, reset, scan order and digit blanking.
// Runs with N=10 and a short SCAN_DIV=4 so scan phases are quick to observe.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_bcd_scan_controller;
  localparam int N = 10;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         done;
  logic [15:0]  bcd_out;
  logic [0:6]   seg_n;
  logic [3:0]   an_n;

  int vecs = 0;
  int errs = 0;

  bcd_scan_controller #(.N(N), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .done(done), .bcd_out(bcd_out), .seg_n(seg_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clock until done rises; cyc = ticks taken, or -1 if it never came.
  task automatic wait_done(output int cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    cyc = (done === 1'b1) ? n : -1;
  endtask

  // Align to the first cycle of the units-digit phase.
  task automatic sync_scan(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (an_n !== 4'b0111 && n < 40) begin
      tick();
      n++;
    end
    if (an_n === 4'b0111) begin
      n = 0;
      while (an_n === 4'b0111 && n < 10) begin
        tick();
        n++;
      end
      ok = (an_n === 4'b1110);
    end
  endtask

  task automatic test_convert_1023();
    in_valid = 1'b1;
    in_data  = 10'd1023;
    tick();
    in_valid = 1'b0;
    vecs++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL accept_ready: got %b want 0", in_ready); end
    for (int i = 1; i <= N; i++) begin
      tick();
      vecs++;
      if (in_ready !== 1'b0 || done !== 1'b0) begin
        errs++; $display("FAIL busy_window cyc %0d: ready=%b done=%b want 0 0", i, in_ready, done);
      end
    end
    tick();
    vecs++;
    if (done !== 1'b1) begin errs++; $display("FAIL done_1023: got %b want 1", done); end
    vecs++;
    if (bcd_out !== 16'h1023) begin errs++; $display("FAIL bcd_1023: got %h want 1023", bcd_out); end
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL ready_after_1023: got %b want 1", in_ready); end
    tick();
    vecs++;
    if (done !== 1'b0) begin errs++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_scan();
    bit ok;
    logic [0:6] exp_seg [4];
    logic [3:0] ea;
    int p;
    exp_seg[0] = 7'b0000110;
    exp_seg[1] = 7'b0010010;
    exp_seg[2] = 7'b0000001;
    exp_seg[3] = 7'b1001111;
    sync_scan(ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL scan_sync: an_n=%b want 1110", an_n); end
    for (int c = 0; c < 32; c++) begin
      p = (c / SD) % 4;
      ea = 4'b0001 << p;
      ea = ~ea;
      vecs++;
      if (an_n !== ea || seg_n !== exp_seg[p]) begin
        errs++; $display("FAIL scan cyc %0d: an=%b seg=%b want an=%b seg=%b", c, an_n, seg_n, ea, exp_seg[p]);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    n = 0;
    while (an_n === 4'b1110 && n < 20) begin
      tick();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (an_n !== 4'b1110) begin errs++; $display("FAIL reset_an: got %b want 1110", an_n); end
    vecs++;
    if (seg_n !== 7'b0000001) begin errs++; $display("FAIL reset_seg: got %b want 0000001", seg_n); end
    vecs++;
    if (bcd_out !== 16'h0000) begin errs++; $display("FAIL reset_bcd: got %h want 0000", bcd_out); end
    vecs++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL reset_hs: ready=%b done=%b want 1 0", in_ready, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= SD; i++) begin
      tick();
      vecs++;
      if (i < SD && an_n !== 4'b1110) begin
        errs++; $display("FAIL scan_restart cyc %0d: got %b want 1110", i, an_n);
      end else if (i == SD && an_n !== 4'b1101) begin
        errs++; $display("FAIL scan_restart cyc %0d: got %b want 1101", i, an_n);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int cyc;
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
    in_valid = 1'b1;
    in_data  = 10'd0;
    tick();
    in_data = 10'd999;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vecs++;
    if (n != N + 1) begin errs++; $display("FAIL b2b_gap: got %0d want %0d", n, N + 1); end
    vecs++;
    if (done !== 1'b1 || bcd_out !== 16'h0000) begin
      errs++; $display("FAIL b2b_first: done=%b bcd=%h want 1 0000", done, bcd_out);
    end
    tick();
    in_valid = 1'b0;
    vecs++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b_second_accept: ready=%b want 0", in_ready); end
    wait_done(cyc);
    vecs++;
    if (cyc != N + 1) begin errs++; $display("FAIL b2b_latency: got %0d want %0d", cyc, N + 1); end
    vecs++;
    if (bcd_out !== 16'h0999) begin errs++; $display("FAIL b2b_bcd: got %h want 0999", bcd_out); end
  endtask

  task automatic test_reset_mid_conv();
    int cyc;
    in_valid = 1'b1;
    in_data  = 10'd512;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (done !== 1'b0 || bcd_out !== 16'h0000 || in_ready !== 1'b1) begin
      errs++; $display("FAIL abort: done=%b bcd=%h ready=%b want 0 0000 1", done, bcd_out, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      tick();
      vecs++;
      if (done !== 1'b0 || bcd_out !== 16'h0000) begin
        errs++; $display("FAIL abort_quiet cyc %0d: done=%b bcd=%h want 0 0000", i, done, bcd_out);
      end
    end
    in_valid = 1'b1;
    in_data  = 10'd512;
    tick();
    in_valid = 1'b0;
    wait_done(cyc);
    vecs++;
    if (cyc != N + 1) begin errs++; $display("FAIL post_reset_latency: got %0d want %0d", cyc, N + 1); end
    vecs++;
    if (bcd_out !== 16'h0512) begin errs++; $display("FAIL post_reset_bcd: got %h want 0512", bcd_out); end
  endtask

  task automatic test_leading_zero();
    logic [0:6]  z;
    logic [0:6]  exp_seg [4];
    logic [N-1:0] val;
    logic [15:0] exp_bcd;
    logic [3:0]  ea;
    int cyc;
    int p;
    bit ok;
`ifdef LEADING_ZERO_BLANK_EN
    z = 7'b1111111;
`else
    z = 7'b0000001;
`endif
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin
          val = 10'd7;  exp_bcd = 16'h0007;
          exp_seg[0] = 7'b0001111; exp_seg[1] = z; exp_seg[2] = z; exp_seg[3] = z;
        end
        1: begin
          val = 10'd40; exp_bcd = 16'h0040;
          exp_seg[0] = 7'b0000001; exp_seg[1] = 7'b1001100; exp_seg[2] = z; exp_seg[3] = z;
        end
        default: begin
          val = 10'd0;  exp_bcd = 16'h0000;
          exp_seg[0] = 7'b0000001; exp_seg[1] = z; exp_seg[2] = z; exp_seg[3] = z;
        end
      endcase
      in_valid = 1'b1;
      in_data  = val;
      tick();
      in_valid = 1'b0;
      wait_done(cyc);
      vecs++;
      if (cyc != N + 1 || bcd_out !== exp_bcd) begin
        errs++; $display("FAIL lz_convert %0d: cyc=%0d bcd=%h want %0d %h", val, cyc, bcd_out, N + 1, exp_bcd);
      end
      sync_scan(ok);
      vecs++;
      if (!ok) begin errs++; $display("FAIL lz_sync %0d: an_n=%b want 1110", val, an_n); end
      for (int c = 0; c < 16; c++) begin
        p = c / SD;
        ea = 4'b0001 << p;
        ea = ~ea;
        vecs++;
        if (an_n !== ea || seg_n !== exp_seg[p]) begin
          errs++; $display("FAIL lz_scan %0d cyc %0d: an=%b seg=%b want an=%b seg=%b", val, c, an_n, seg_n, ea, exp_seg[p]);
        end
        tick();
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #22;
    rst_n = 1'b1;
    tick();
    test_convert_1023();
    test_scan();
    test_reset();
    test_back_to_back();
    test_reset_mid_conv();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
